sample_bank_writer: RTL

Writer side of the correlator's sample memories. It accepts a stream of 4-bit samples over a valid/ready handshake and fills bank A, then bank B, with N = 1, 2, 4 or 8 samples. N is selected by the same 2-bit sample-count encoding the correlator uses. Once both banks are full it asserts done and serves a combinational read port, indexed by the correlator's sum counter.

---
 rtl/sample_bank_writer_pkg.sv | 22 ++
 rtl/sample_ram.sv | 21 ++
 rtl/sample_bank_writer.sv | 103 ++++++++++
 3 files changed

// File: rtl/sample_bank_writer_pkg.sv
// Shared types and constants for the correlator sample memories.
// The count-code decode is shared so the correlator and the writer agree on N.
package sample_bank_writer_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned IDX_W  = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      LOAD_B = 2'd2,
      DONE   = 2'd3
   } state_t;

   // 2-bit sample-count code to N: 0->1, 1->2, 2->4, 3->8
   function automatic logic [ADDR_W-1:0] count_to_n(input logic [1:0] code);
      return ADDR_W'(1) << code;
   endfunction

endpackage

// File: rtl/sample_ram.sv
// One sample bank: synchronous write, asynchronous read, no reset.
module sample_ram
   import sample_bank_writer_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data_c
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/sample_bank_writer.sv
// Loads N samples into bank A then bank B over valid/ready, then serves
// a masked combinational read port to the correlator.
module sample_bank_writer
   import sample_bank_writer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [1:0]        count_sel,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wr_idx, wr_idx_nxt;
   logic [ADDR_W-1:0] n_reg, n_nxt;
   logic              xfer, last;
   logic              we_a, we_b;
   logic              rd_ok;
   logic [DATA_W-1:0] ram_a_c, ram_b_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         wr_idx <= '0;
         n_reg  <= ADDR_W'(1);
      end else begin
         state  <= state_nxt;
         wr_idx <= wr_idx_nxt;
         n_reg  <= n_nxt;
      end
   end

   // ready and done decode straight from the state register
   assign in_ready = (state == LOAD_A) || (state == LOAD_B);
   assign done     = (state == DONE);
   assign xfer     = in_valid && in_ready;
   assign last     = (wr_idx == n_reg - ADDR_W'(1));

   always_comb begin
      state_nxt  = state;
      wr_idx_nxt = wr_idx;
      n_nxt      = n_reg;
      case (state)
         IDLE, DONE: begin
            if (load_start) begin
               n_nxt      = count_to_n(count_sel);
               wr_idx_nxt = '0;
               state_nxt  = LOAD_A;
            end
         end
         LOAD_A: begin
            if (xfer) begin
               if (last) begin
                  wr_idx_nxt = '0;
                  state_nxt  = LOAD_B;
               end else begin
                  wr_idx_nxt = wr_idx + ADDR_W'(1);
               end
            end
         end
         LOAD_B: begin
            if (xfer) begin
               if (last) state_nxt  = DONE;
               else      wr_idx_nxt = wr_idx + ADDR_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign we_a = xfer && (state == LOAD_A);
   assign we_b = xfer && (state == LOAD_B);

   sample_ram u_bank_a (
      .clk       (clk),
      .we        (we_a),
      .wr_addr   (wr_idx[IDX_W-1:0]),
      .wr_data   (in_data),
      .rd_addr   (rd_addr[IDX_W-1:0]),
      .rd_data_c (ram_a_c)
   );

   sample_ram u_bank_b (
      .clk       (clk),
      .we        (we_b),
      .wr_addr   (wr_idx[IDX_W-1:0]),
      .wr_data   (in_data),
      .rd_addr   (rd_addr[IDX_W-1:0]),
      .rd_data_c (ram_b_c)
   );

   // n_reg <= DEPTH, so this bound also keeps the low-bit index in range
   assign rd_ok = done && (rd_addr < n_reg);
   assign rd_a  = rd_ok ? ram_a_c : '0;
   assign rd_b  = rd_ok ? ram_b_c : '0;

endmodule
